uart_wb_master: RTL and testbench

- Command-driven Wishbone initiator; the counterpart to the existing Wishbone-slave UART.
- Consumes command bytes from a receive-side byte FIFO and issues single 32-bit Wishbone read/write cycles.
- Pushes response bytes into a transmit-side byte FIFO.
- Gives a UART host (or testbench) bus-master access to the user-project address space.

---
 rtl/uart_wb_pkg.sv | 21 ++
 rtl/uart_wb_resp_buf.sv | 37 +++
 rtl/uart_wb_master.sv | 204 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART-driven Wishbone initiator.
package uart_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_WB,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_WR_DEFAULT  = 8'h57;
    localparam logic [7:0] CMD_RD_DEFAULT  = 8'h52;
    localparam logic [7:0] RSP_ACK_DEFAULT = 8'h06;
    localparam logic [7:0] RSP_NAK_DEFAULT = 8'h15;

    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 4;

endpackage

// File: rtl/uart_wb_resp_buf.sv
// Response byte buffer: holds 1 or 4 queued bytes and drains them MSB-first
// into the tx FIFO, one per cycle while the FIFO is not full.
module uart_wb_resp_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        load_four,
    input  logic [31:0] load_data,
    input  logic        active,
    input  logic        fifotx_full,
    output logic        fifotx_w_en,
    output logic [7:0]  fifotx_w_data,
    output logic        last_push
);

    logic [31:0] buf_reg;
    logic [2:0]  cnt_reg;

    assign fifotx_w_en   = active && (cnt_reg != 3'd0) && !fifotx_full;
    assign fifotx_w_data = buf_reg[31:24];
    assign last_push     = fifotx_w_en && (cnt_reg == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            // A single byte is parked in the top lane so both cases pop the same way.
            buf_reg <= load_four ? load_data : {load_data[7:0], 24'h0};
            cnt_reg <= load_four ? 3'd4 : 3'd1;
        end else if (fifotx_w_en) begin
            buf_reg <= {buf_reg[23:0], 8'h0};
            cnt_reg <= cnt_reg - 3'd1;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// Byte-command driven single-beat Wishbone initiator with a byte response path.
// Define UART_WB_CSUM_EN to require a trailing XOR checksum byte on every command.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int         WB_TIMEOUT = 256,
    parameter logic [7:0] CMD_WR     = CMD_WR_DEFAULT,
    parameter logic [7:0] CMD_RD     = CMD_RD_DEFAULT,
    parameter logic [7:0] RSP_ACK    = RSP_ACK_DEFAULT,
    parameter logic [7:0] RSP_NAK    = RSP_NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fiforx_empty,
    input  logic [7:0]  fiforx_r_data,
    output logic        fiforx_r_en,
    input  logic        fifotx_full,
    output logic        fifotx_w_en,
    output logic [7:0]  fifotx_w_data,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        err
);

    localparam int TMO_W = $clog2(WB_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WB_TIMEOUT - 1);

`ifdef UART_WB_CSUM_EN
    localparam state_t ST_BODY_END = ST_CSUM;
`else
    localparam state_t ST_BODY_END = ST_WB;
`endif

    state_t            state_reg;
    logic [1:0]        cnt_reg;
    logic              op_wr_reg;
    logic [31:0]       adr_reg;
    logic [31:0]       dat_reg;
    logic              cyc_reg;
    logic              err_reg;
    logic [TMO_W-1:0]  tmo_reg;
`ifdef UART_WB_CSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic        is_cmd;
    logic        ack_hit;
    logic        tmo_hit;
    logic        rsp_load;
    logic        rsp_four;
    logic        rsp_nak;
    logic [31:0] rsp_data;
    logic        last_push;

    assign fiforx_r_en = !fiforx_empty &&
                         (state_reg inside {ST_IDLE, ST_ADDR, ST_DATA, ST_CSUM});
    assign is_cmd  = (fiforx_r_data == CMD_WR) || (fiforx_r_data == CMD_RD);
    assign ack_hit = (state_reg == ST_WB) && cyc_reg && wbm_ack_i;
    assign tmo_hit = (state_reg == ST_WB) && cyc_reg && !wbm_ack_i && (tmo_reg == TMO_LAST);

    // Response selection; a load always coincides with the move into RESP.
    always_comb begin
        rsp_load = 1'b0;
        rsp_four = 1'b0;
        rsp_nak  = 1'b0;
        rsp_data = {24'h0, RSP_NAK};
        case (state_reg)
            ST_IDLE: if (fiforx_r_en && !is_cmd) begin
                rsp_load = 1'b1;
                rsp_nak  = 1'b1;
            end
`ifdef UART_WB_CSUM_EN
            ST_CSUM: if (fiforx_r_en && (fiforx_r_data != csum_reg)) begin
                rsp_load = 1'b1;
                rsp_nak  = 1'b1;
            end
`endif
            ST_WB: begin
                if (ack_hit) begin
                    rsp_load = 1'b1;
                    if (op_wr_reg) begin
                        rsp_data = {24'h0, RSP_ACK};
                    end else begin
                        rsp_four = 1'b1;
                        rsp_data = wbm_dat_i;
                    end
                end else if (tmo_hit) begin
                    rsp_load = 1'b1;
                    rsp_nak  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_wr_reg <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            cyc_reg   <= 1'b0;
            err_reg   <= 1'b0;
            tmo_reg   <= '0;
`ifdef UART_WB_CSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            err_reg <= rsp_load && rsp_nak;
            case (state_reg)
                ST_IDLE: if (fiforx_r_en) begin
                    cnt_reg   <= '0;
                    op_wr_reg <= (fiforx_r_data == CMD_WR);
`ifdef UART_WB_CSUM_EN
                    csum_reg  <= fiforx_r_data;
`endif
                    state_reg <= is_cmd ? ST_ADDR : ST_RESP;
                end
                ST_ADDR: if (fiforx_r_en) begin
                    adr_reg <= {adr_reg[23:0], fiforx_r_data};
                    cnt_reg <= cnt_reg + 2'd1;
`ifdef UART_WB_CSUM_EN
                    csum_reg <= csum_reg ^ fiforx_r_data;
`endif
                    if (cnt_reg == 2'(ADDR_BYTES - 1)) begin
                        cnt_reg <= '0;
                        tmo_reg <= '0;
                        if (op_wr_reg) begin
                            state_reg <= ST_DATA;
                        end else begin
                            state_reg <= ST_BODY_END;
                            cyc_reg   <= (ST_BODY_END == ST_WB);
                        end
                    end
                end
                ST_DATA: if (fiforx_r_en) begin
                    dat_reg <= {dat_reg[23:0], fiforx_r_data};
                    cnt_reg <= cnt_reg + 2'd1;
`ifdef UART_WB_CSUM_EN
                    csum_reg <= csum_reg ^ fiforx_r_data;
`endif
                    if (cnt_reg == 2'(DATA_BYTES - 1)) begin
                        cnt_reg   <= '0;
                        tmo_reg   <= '0;
                        state_reg <= ST_BODY_END;
                        cyc_reg   <= (ST_BODY_END == ST_WB);
                    end
                end
`ifdef UART_WB_CSUM_EN
                ST_CSUM: if (fiforx_r_en) begin
                    if (fiforx_r_data == csum_reg) begin
                        state_reg <= ST_WB;
                        cyc_reg   <= 1'b1;
                        tmo_reg   <= '0;
                    end else begin
                        state_reg <= ST_RESP;
                    end
                end
`endif
                ST_WB: begin
                    if (ack_hit || tmo_hit) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= ST_RESP;
                    end else begin
                        tmo_reg <= tmo_reg + TMO_W'(1);
                    end
                end
                ST_RESP: if (last_push) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    uart_wb_resp_buf u_resp_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (rsp_load),
        .load_four     (rsp_four),
        .load_data     (rsp_data),
        .active        (state_reg == ST_RESP),
        .fifotx_full   (fifotx_full),
        .fifotx_w_en   (fifotx_w_en),
        .fifotx_w_data (fifotx_w_data),
        .last_push     (last_push)
    );

    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = cyc_reg & op_wr_reg;
    assign wbm_sel_o = {4{cyc_reg}};
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed self-checking bench for uart_wb_master with FIFO and Wishbone slave models.
module tb_uart_wb_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fiforx_empty;
    logic [7:0]  fiforx_r_data;
    logic        fiforx_r_en;
    logic        fifotx_full = 1'b0;
    logic        fifotx_w_en;
    logic [7:0]  fifotx_w_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy, err;

    always #5 clk = ~clk;

    uart_wb_master #(.WB_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .fiforx_empty(fiforx_empty), .fiforx_r_data(fiforx_r_data), .fiforx_r_en(fiforx_r_en),
        .fifotx_full(fifotx_full), .fifotx_w_en(fifotx_w_en), .fifotx_w_data(fifotx_w_data),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .busy(busy), .err(err)
    );

    // rx FIFO model (first-word-fall-through)
    logic [7:0] rx_mem [256];
    logic [7:0] rx_wr = 8'd0;
    logic [7:0] rx_rd = 8'd0;
    assign fiforx_empty  = (rx_rd == rx_wr);
    assign fiforx_r_data = rx_mem[rx_rd];
    always @(posedge clk) if (fiforx_r_en) rx_rd <= rx_rd + 8'd1;

    // tx FIFO model
    logic [7:0] tx_mem [256];
    int tx_wr = 0;
    int push_full_viol = 0;
    always @(posedge clk) begin
        if (fifotx_w_en) begin
            tx_mem[tx_wr[7:0]] <= fifotx_w_data;
            tx_wr <= tx_wr + 1;
            if (fifotx_full) push_full_viol <= push_full_viol + 1;
        end
    end

    // Wishbone slave and bus monitor
    logic        slave_en = 1'b1;
    logic [31:0] slave_rdata = 32'h0;
    int          ack_delay = 2;
    logic        ack_gen = 1'b0;
    logic        spurious_ack = 1'b0;
    assign wbm_ack_i = ack_gen | spurious_ack;
    assign wbm_dat_i = slave_rdata;

    int stb_run = 0, stb_cycles = 0, cyc_starts = 0, err_pulses = 0;
    int stbcyc_viol = 0, pop_empty_viol = 0, cycle_no = 0;
    int last_pop_cycle = -100, ack_cycle = -100, pop_to_cyc = -1, ack_to_push = -1;
    logic ack_pending = 1'b0, cyc_prev = 1'b0;
    logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_sel = 4'h0;

    always @(negedge clk) begin
        cycle_no++;
        if (wbm_cyc_o !== wbm_stb_o) stbcyc_viol++;
        if (err) err_pulses++;
        if (fiforx_r_en && fiforx_empty) pop_empty_viol++;
        if (wbm_cyc_o && !cyc_prev) begin
            cyc_starts++;
            pop_to_cyc = cycle_no - last_pop_cycle;
        end
        if (fiforx_r_en) last_pop_cycle = cycle_no;
        if (fifotx_w_en && ack_pending) begin
            ack_to_push = cycle_no - ack_cycle;
            ack_pending = 1'b0;
        end
        cyc_prev = wbm_cyc_o;
        if (wbm_cyc_o && wbm_stb_o) begin
            stb_cycles++;
            stb_run++;
            ack_gen = slave_en && (stb_run == ack_delay);
        end else begin
            stb_run = 0;
            ack_gen = 1'b0;
        end
        if (ack_gen && wbm_cyc_o) begin
            ack_cycle   = cycle_no;
            ack_pending = 1'b1;
            cap_adr = wbm_adr_o;
            cap_dat = wbm_dat_o;
            cap_we  = wbm_we_o;
            cap_sel = wbm_sel_o;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] tb_csum = 8'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] txb(input int i);
        return {24'h0, tx_mem[i[7:0]]};
    endfunction

    task automatic put(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 8'd1;
        tb_csum = tb_csum ^ b;
    endtask

    task automatic end_cmd();
`ifdef UART_WB_CSUM_EN
        put(tb_csum);
`endif
        tb_csum = 8'h0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || rx_rd != rx_wr) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 400) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected=<400", tag, n);
        end
    endtask

    int b_tx, b_cs, b_err, b_stb;
    task automatic snap();
        b_tx = tx_wr; b_cs = cyc_starts; b_err = err_pulses; b_stb = stb_cycles;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("rst_we_sel", {27'h0, wbm_we_o, wbm_sel_o}, 32'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_dat", wbm_dat_o, 32'h0);
        chk("rst_fifo_en", {30'h0, fifotx_w_en, fiforx_r_en}, 32'h0);
        chk("rst_busy_err", {30'h0, busy, err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 3000_0004 <- DEADBEEF
        snap();
        put(8'h57); put(8'h30); put(8'h00); put(8'h00); put(8'h04);
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF); end_cmd();
        wait_done("wr");
        chk("wr_tx_count", 32'(tx_wr - b_tx), 32'd1);
        chk("wr_tx_byte", txb(b_tx), 32'h06);
        chk("wr_cyc_starts", 32'(cyc_starts - b_cs), 32'd1);
        chk("wr_stb_cycles", 32'(stb_cycles - b_stb), 32'd2);
        chk("wr_adr", cap_adr, 32'h3000_0004);
        chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
        chk("wr_we_sel", {27'h0, cap_we, cap_sel}, 32'h1F);
        chk("wr_pop_to_cyc", 32'(pop_to_cyc), 32'd1);
        chk("wr_ack_to_push", 32'(ack_to_push), 32'd1);
        chk("wr_err", 32'(err_pulses - b_err), 32'd0);
        $display("txn write adr=30000004 tx=%h", txb(b_tx));

        // Read 3000_0008 -> 12345678
        snap();
        slave_rdata = 32'h1234_5678;
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h08); end_cmd();
        wait_done("rd");
        chk("rd_tx_count", 32'(tx_wr - b_tx), 32'd4);
        chk("rd_tx_b0", txb(b_tx), 32'h12);
        chk("rd_tx_b1", txb(b_tx + 1), 32'h34);
        chk("rd_tx_b2", txb(b_tx + 2), 32'h56);
        chk("rd_tx_b3", txb(b_tx + 3), 32'h78);
        chk("rd_adr", cap_adr, 32'h3000_0008);
        chk("rd_we_sel", {27'h0, cap_we, cap_sel}, 32'h0F);
        chk("rd_ack_to_push", 32'(ack_to_push), 32'd1);
        $display("txn read adr=30000008 tx=%h %h %h %h", txb(b_tx), txb(b_tx+1), txb(b_tx+2), txb(b_tx+3));

        // Timeout: slave never acks
        snap();
        slave_en = 1'b0;
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h10); end_cmd();
        wait_done("tmo");
        slave_en = 1'b1;
        chk("tmo_stb_cycles", 32'(stb_cycles - b_stb), 32'd16);
        chk("tmo_cyc_starts", 32'(cyc_starts - b_cs), 32'd1);
        chk("tmo_err", 32'(err_pulses - b_err), 32'd1);
        chk("tmo_tx_count", 32'(tx_wr - b_tx), 32'd1);
        chk("tmo_tx_byte", txb(b_tx), 32'h15);
        chk("tmo_busy", 32'(busy), 32'h0);
        $display("txn timeout tx=%h", txb(b_tx));

        // Bad command, then a good read
        snap();
        put(8'h41); tb_csum = 8'h0;
        wait_done("bad");
        chk("bad_tx_count", 32'(tx_wr - b_tx), 32'd1);
        chk("bad_tx_byte", txb(b_tx), 32'h15);
        chk("bad_cyc_starts", 32'(cyc_starts - b_cs), 32'd0);
        chk("bad_err", 32'(err_pulses - b_err), 32'd1);
        $display("txn badcmd tx=%h", txb(b_tx));
        snap();
        slave_rdata = 32'hA5A5_0F0F;
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h14); end_cmd();
        wait_done("rd2");
        chk("rd2_adr", cap_adr, 32'h3000_0014);
        chk("rd2_tx_count", 32'(tx_wr - b_tx), 32'd4);
        chk("rd2_tx_b0", txb(b_tx), 32'hA5);
        $display("txn read adr=30000014 tx0=%h", txb(b_tx));

        // Ack while idle is ignored
        snap();
        spurious_ack = 1'b1;
        repeat (3) @(negedge clk);
        spurious_ack = 1'b0;
        @(negedge clk);
        chk("spur_busy", 32'(busy), 32'h0);
        chk("spur_tx_count", 32'(tx_wr - b_tx), 32'd0);
        $display("txn spurious_ack busy=%0d", busy);

        // Backpressure and rx gap mid-address
        snap();
        slave_rdata = 32'hCAFE_F00D;
        fifotx_full = 1'b1;
        put(8'h52); put(8'h30); put(8'h00);
        repeat (10) @(negedge clk);
        chk("bp_stall_busy", 32'(busy), 32'h1);
        chk("bp_partial_adr", wbm_adr_o & 32'h0000_FFFF, 32'h0000_3000);
        put(8'h00); put(8'h0C); end_cmd();
        repeat (30) @(negedge clk);
        chk("bp_no_push_full", 32'(tx_wr - b_tx), 32'd0);
        fifotx_full = 1'b0;
        repeat (2) @(negedge clk);
        fifotx_full = 1'b1;
        repeat (3) @(negedge clk);
        fifotx_full = 1'b0;
        wait_done("bp");
        chk("bp_adr", cap_adr, 32'h3000_000C);
        chk("bp_tx_count", 32'(tx_wr - b_tx), 32'd4);
        chk("bp_tx_b0", txb(b_tx), 32'hCA);
        chk("bp_tx_b1", txb(b_tx + 1), 32'hFE);
        chk("bp_tx_b2", txb(b_tx + 2), 32'hF0);
        chk("bp_tx_b3", txb(b_tx + 3), 32'h0D);
        chk("bp_push_while_full", 32'(push_full_viol), 32'd0);
        chk("bp_pop_while_empty", 32'(pop_empty_viol), 32'd0);
        $display("txn backpressure tx=%h %h %h %h", txb(b_tx), txb(b_tx+1), txb(b_tx+2), txb(b_tx+3));

        // Reset while a bus cycle is open
        snap();
        slave_en = 1'b0;
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h18); end_cmd();
        begin
            int n = 0;
            while (!wbm_cyc_o && n < 50) begin @(negedge clk); n++; end
            chk("rstop_cyc_seen", 32'(wbm_cyc_o), 32'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rstop_cyc_async", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slave_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstop_busy", 32'(busy), 32'h0);
        chk("rstop_no_tx", 32'(tx_wr - b_tx), 32'd0);
        $display("txn reset_mid_cycle busy=%0d", busy);

`ifdef UART_WB_CSUM_EN
        // Correct checksum 52^30^00^00^08 = 6A
        snap();
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h08); put(8'h6A);
        tb_csum = 8'h0;
        wait_done("cs_ok");
        chk("cs_ok_cyc", 32'(cyc_starts - b_cs), 32'd1);
        chk("cs_ok_tx_count", 32'(tx_wr - b_tx), 32'd4);
        $display("txn csum_ok tx0=%h", txb(b_tx));
        // Wrong checksum
        snap();
        put(8'h52); put(8'h30); put(8'h00); put(8'h00); put(8'h08); put(8'h00);
        tb_csum = 8'h0;
        wait_done("cs_bad");
        chk("cs_bad_cyc", 32'(cyc_starts - b_cs), 32'd0);
        chk("cs_bad_tx_count", 32'(tx_wr - b_tx), 32'd1);
        chk("cs_bad_tx_byte", txb(b_tx), 32'h15);
        chk("cs_bad_err", 32'(err_pulses - b_err), 32'd1);
        $display("txn csum_bad tx=%h", txb(b_tx));
`endif

        chk("stb_eq_cyc", 32'(stbcyc_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
